uart_tx_ctrl: RTL

Frame controller and serializer for the UART transmitter, directly downstream of the parity calculator. Accepts a parallel byte on a one-cycle Data_valid handshake and captures the parity calculator's par_bit in the same cycle. Drives the serial line as start bit, data LSB-first, optional parity and stop bit(s). One bit per CLK cycle; CLK is the baud-rate clock.

---
 rtl/uart_tx_pkg.sv | 25 ++
 rtl/uart_tx_serializer.sv | 45 ++++
 rtl/uart_tx_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller: state encoding,
// default data width and serial line levels.
package uart_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  localparam logic [2:0] IDLE_ENC   = 3'd0;
  localparam logic [2:0] START_ENC  = 3'd1;
  localparam logic [2:0] DATA_ENC   = 3'd2;
  localparam logic [2:0] PARITY_ENC = 3'd3;
  localparam logic [2:0] STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = IDLE_ENC,
    START  = START_ENC,
    DATA   = DATA_ENC,
    PARITY = PARITY_ENC,
    STOP   = STOP_ENC
  } state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first data shift register with a bit counter; ser_done flags the last
// data bit so the controller can leave the data phase without wrapping.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic                  cnt_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_r;
  logic [CNT_W-1:0]      bit_cnt_r;

  // Shift register and data bit counter; load restarts both.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
    end else if (load) begin
      shift_r   <= data;
      bit_cnt_r <= '0;
    end else begin
      if (shift_en) begin
        shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
      end
      if (cnt_en && (bit_cnt_r != LAST_CNT)) begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign ser_data = shift_r[0];
  assign ser_done = (bit_cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: accepts a byte plus captured parity and
// drives start, LSB-first data, optional parity and stop bits on TX_OUT.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  busy
);

  // Stop counter is one bit wide because only one or two stop bits are legal.
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_e state_r, state_s;
  logic   tx_out_r, tx_out_s;
  logic   busy_r, busy_s;
  logic   stop_cnt_r, stop_cnt_s;
  logic   par_en_r, par_en_s;
  logic   par_bit_r, par_bit_s;
  logic   load_s, shift_en_s, cnt_en_s;
  logic   ser_data_s, ser_done_s;
  logic   unused_par_typ_s;

  // Parity type only configures the upstream calculator.
  assign unused_par_typ_s = PAR_TYP;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .rst      (RST),
    .load     (load_s),
    .shift_en (shift_en_s),
    .cnt_en   (cnt_en_s),
    .data     (P_DATA),
    .ser_data (ser_data_s),
    .ser_done (ser_done_s)
  );

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s    = state_r;
    tx_out_s   = tx_out_r;
    busy_s     = busy_r;
    stop_cnt_s = stop_cnt_r;
    par_en_s   = par_en_r;
    par_bit_s  = par_bit_r;
    load_s     = 1'b0;
    shift_en_s = 1'b0;
    cnt_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (Data_valid) begin
          load_s    = 1'b1;
          par_en_s  = PAR_EN;
          par_bit_s = par_bit;
          state_s   = START;
          tx_out_s  = START_BIT;
          busy_s    = 1'b1;
        end else begin
          state_s  = IDLE;
          tx_out_s = IDLE_LVL;
          busy_s   = 1'b0;
        end
      end
      START: begin
        state_s    = DATA;
        tx_out_s   = ser_data_s;
        shift_en_s = 1'b1;
      end
      DATA: begin
        if (ser_done_s) begin
          stop_cnt_s = 1'b0;
          if (par_en_r) begin
            state_s  = PARITY;
            tx_out_s = par_bit_r;
          end else begin
            state_s  = STOP;
            tx_out_s = STOP_BIT;
          end
        end else begin
          tx_out_s   = ser_data_s;
          shift_en_s = 1'b1;
          cnt_en_s   = 1'b1;
        end
      end
      PARITY: begin
        state_s    = STOP;
        tx_out_s   = STOP_BIT;
        stop_cnt_s = 1'b0;
      end
      STOP: begin
        if (stop_cnt_r == STOP_LAST) begin
          state_s  = IDLE;
          tx_out_s = IDLE_LVL;
          busy_s   = 1'b0;
        end else begin
          tx_out_s   = STOP_BIT;
          stop_cnt_s = stop_cnt_r + 1'b1;
        end
      end
      default: begin
        state_s  = IDLE;
        tx_out_s = IDLE_LVL;
        busy_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      tx_out_r   <= IDLE_LVL;
      busy_r     <= 1'b0;
      stop_cnt_r <= 1'b0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      tx_out_r   <= tx_out_s;
      busy_r     <= busy_s;
      stop_cnt_r <= stop_cnt_s;
      par_en_r   <= par_en_s;
      par_bit_r  <= par_bit_s;
    end
  end

  assign TX_OUT = tx_out_r;
  assign busy   = busy_r;

endmodule
